// File: rtl/colwin_pkg.sv
`default_nettype none
// ============================================================================
// Module   : colwin_pkg
// Desc     : Shared types, default sizes and window packing helper for the
//            column window packer. COLWIN_ZERO_PAD_EN adds the FLUSH state.
// Revision : 1.0 - initial release
// ============================================================================
package colwin_pkg;

   localparam int DEF_TILE_H   = 6;
   localparam int DEF_UNIT_NUM = 16;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_K        = 3;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
`ifdef COLWIN_ZERO_PAD_EN
      STREAM = 2'd1,
      FLUSH  = 2'd2
`else
      STREAM = 2'd1
`endif
   } colwin_state_t;

   // Bit offset of window slot s_idx belonging to unit u_idx.
   function automatic int slot_offset(input int u_idx, input int s_idx,
                                      input int k_num, input int slot_w);
      return (u_idx * k_num + s_idx) * slot_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/colwin_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : colwin_shift_reg
// Desc     : K-slot column shift register; slot K-1 is the incoming column,
//            so only the K-1 older slots are stored. Clear preloads zeros.
// Revision : 1.0 - initial release
// ============================================================================
module colwin_shift_reg
   import colwin_pkg::*;
#(
   parameter int K     = DEF_K,
   parameter int COL_W = DEF_UNIT_NUM * DEF_TILE_H * DEF_DATA_W
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               shift_en,
   input  logic [COL_W-1:0]   din,
   output logic [K*COL_W-1:0] next_slots
);

   logic [(K-1)*COL_W-1:0] r_hist;

   // Window as it stands once din has shifted in; slot 0 is the oldest.
   assign next_slots = {din, r_hist};

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_hist <= '0;
      end else if (shift_en) begin
         r_hist <= next_slots[K*COL_W-1:COL_W];
      end
   end

endmodule
`default_nettype wire

// File: rtl/col_window_packer.sv
`default_nettype none
// ============================================================================
// Module   : col_window_packer
// Desc     : Packs a stream of columns into K-column sliding windows with a
//            single output register. COLWIN_ZERO_PAD_EN enables zero padding.
// Revision : 1.0 - initial release
// ============================================================================
module col_window_packer
   import colwin_pkg::*;
#(
   parameter int TILE_H   = DEF_TILE_H,
   parameter int UNIT_NUM = DEF_UNIT_NUM,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int K        = DEF_K
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [UNIT_NUM*TILE_H*DATA_W-1:0]    column_data_in,
   input  logic                                 column_valid,
   input  logic                                 column_last,
   output logic                                 column_ready,
   output logic [UNIT_NUM*K*TILE_H*DATA_W-1:0]  win_data,
   output logic                                 win_valid,
   output logic                                 win_last,
   input  logic                                 win_ready,
   output logic                                 short_line
);

   localparam int c_TD    = TILE_H * DATA_W;
   localparam int c_COL_W = UNIT_NUM * c_TD;
   localparam int c_WIN_W = K * c_COL_W;
   localparam int c_CW    = $clog2(K + 1);
`ifdef COLWIN_ZERO_PAD_EN
   localparam int c_PAD   = (K - 1) / 2;
`else
   localparam int c_PAD   = 0;
`endif
   localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(K);
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(K - 1);
   localparam logic [c_CW-1:0] c_CNT_PRE  = c_CW'(c_PAD);

   colwin_state_t      r_state;
   logic [c_CW-1:0]    r_cnt;
   logic               r_win_valid;
   logic               r_win_last;
   logic               r_short_line;
   logic [c_WIN_W-1:0] r_win_data;

   logic               w_out_free;
   logic               w_accept;
   logic               w_full_next;
   logic               w_shift_en;
   logic               w_clear;
   logic [c_CW-1:0]    w_cnt_inc;
   logic [c_COL_W-1:0] w_shift_din;
   logic [c_WIN_W-1:0] w_next_slots;
   logic [c_WIN_W-1:0] w_win_next;

   assign w_out_free  = !r_win_valid || win_ready;
   assign w_accept    = column_valid && column_ready;
   // True when the column shifting in this cycle completes a window.
   assign w_full_next = (r_state == STREAM) || (r_cnt >= c_CNT_LAST);
   assign w_cnt_inc   = w_full_next ? c_CNT_FULL : r_cnt + c_CW'(1);

`ifdef COLWIN_ZERO_PAD_EN
   localparam logic [1:0] c_FLUSH_N   = 2'(c_PAD);
   localparam logic [1:0] c_FLUSH_ONE = 2'd1;

   logic [1:0] r_flush_left;
   logic       w_flush_step;

   assign column_ready = !rst && w_out_free && (r_state != FLUSH);
   assign w_flush_step = (r_state == FLUSH) && w_out_free;
   assign w_shift_en   = w_accept || w_flush_step;
   assign w_shift_din  = (r_state == FLUSH) ? '0 : column_data_in;
   assign w_clear      = w_flush_step && (r_flush_left == c_FLUSH_ONE);
`else
   assign column_ready = !rst && w_out_free;
   assign w_shift_en   = w_accept;
   assign w_shift_din  = column_data_in;
   assign w_clear      = 1'b0;
`endif

   colwin_shift_reg #(
      .K     (K),
      .COL_W (c_COL_W)
   ) u_shift (
      .clk        (clk),
      .rst        (rst),
      .clear      (w_clear),
      .shift_en   (w_shift_en),
      .din        (w_shift_din),
      .next_slots (w_next_slots)
   );

   for (genvar u = 0; u < UNIT_NUM; u++) begin : g_unit
      for (genvar k = 0; k < K; k++) begin : g_slot
         assign w_win_next[slot_offset(u, k, K, c_TD) +: c_TD] =
            w_next_slots[k*c_COL_W + u*c_TD +: c_TD];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= FILL;
         r_cnt        <= c_CNT_PRE;
         r_win_valid  <= 1'b0;
         r_win_last   <= 1'b0;
         r_short_line <= 1'b0;
         r_win_data   <= '0;
`ifdef COLWIN_ZERO_PAD_EN
         r_flush_left <= 2'd0;
`endif
      end else begin
         r_short_line <= 1'b0;
         if (w_out_free) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
         end
         if (w_accept) begin
            if (w_full_next) begin
               r_win_valid <= 1'b1;
               r_win_data  <= w_win_next;
`ifndef COLWIN_ZERO_PAD_EN
               r_win_last  <= column_last;
`endif
            end
            if (column_last) begin
`ifdef COLWIN_ZERO_PAD_EN
               r_state      <= FLUSH;
               r_cnt        <= w_cnt_inc;
               r_flush_left <= c_FLUSH_N;
`else
               r_state      <= FILL;
               r_cnt        <= '0;
               r_short_line <= !w_full_next;
`endif
            end else begin
               r_state <= w_full_next ? STREAM : FILL;
               r_cnt   <= w_cnt_inc;
            end
         end
`ifdef COLWIN_ZERO_PAD_EN
         // Trailing zero columns; the last one always completes a window.
         if (w_flush_step) begin
            if (w_full_next) begin
               r_win_valid <= 1'b1;
               r_win_data  <= w_win_next;
               r_win_last  <= (r_flush_left == c_FLUSH_ONE);
            end
            if (r_flush_left == c_FLUSH_ONE) begin
               r_state <= FILL;
               r_cnt   <= c_CNT_PRE;
            end else begin
               r_cnt   <= w_cnt_inc;
            end
            r_flush_left <= r_flush_left - 2'd1;
         end
`endif
      end
   end

   assign win_data   = r_win_data;
   assign win_valid  = r_win_valid;
   assign win_last   = r_win_last;
   assign short_line = r_short_line;

endmodule
`default_nettype wire

// File: tb/tb_col_window_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_col_window_packer
// Desc     : Self-checking bench for col_window_packer with a line-level
//            window model; honours COLWIN_ZERO_PAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_col_window_packer;

   localparam int TILE_H   = 6;
   localparam int UNIT_NUM = 16;
   localparam int DATA_W   = 8;
   localparam int K        = 3;
   localparam int TD       = TILE_H * DATA_W;
   localparam int COL_W    = UNIT_NUM * TD;
   localparam int WIN_W    = K * COL_W;
`ifdef COLWIN_ZERO_PAD_EN
   localparam int PAD = (K - 1) / 2;
`else
   localparam int PAD = 0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [COL_W-1:0] column_data_in;
   logic             column_valid;
   logic             column_last;
   logic             column_ready;
   logic [WIN_W-1:0] win_data;
   logic             win_valid;
   logic             win_last;
   logic             win_ready;
   logic             short_line;

   col_window_packer #(
      .TILE_H   (TILE_H),
      .UNIT_NUM (UNIT_NUM),
      .DATA_W   (DATA_W),
      .K        (K)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .column_data_in (column_data_in),
      .column_valid   (column_valid),
      .column_last    (column_last),
      .column_ready   (column_ready),
      .win_data       (win_data),
      .win_valid      (win_valid),
      .win_last       (win_last),
      .win_ready      (win_ready),
      .short_line     (short_line)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIN_W-1:0] data;
      logic             last;
   } win_t;

   typedef struct {
      logic       vld;
      logic       last;
      logic       wrdy;
      logic [7:0] col;
      logic       cr;
      logic       wv;
      logic       wl;
      logic [7:0] s0;
      logic       sh;
   } vec_t;

   win_t             exp_q[$];
   logic [COL_W-1:0] line_q[$];
   vec_t             tbl[$];

   int n_pass    = 0;
   int n_chk     = 0;
   int n_win     = 0;
   int n_short   = 0;
   int exp_short = 0;
   int n_cr_low  = 0;
   int wr_mode   = 0;
   bit acc_seen  = 0;
   bit stall_prev = 0;
   logic [WIN_W-1:0] prev_data;
   logic             prev_last;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endfunction

   function automatic void chk_win(input logic [WIN_W-1:0] d, input logic l, input win_t e);
      n_chk++;
      if (d === e.data && l === e.last) n_pass++;
      else $display("FAIL window: got last=%b data[31:0]=%h, want last=%b data[31:0]=%h",
                    l, d[31:0], e.last, e.data[31:0]);
   endfunction

   function automatic logic [COL_W-1:0] col_of(input logic [7:0] v);
      return {(COL_W/8){v}};
   endfunction

   function automatic logic [COL_W-1:0] rand_col();
      logic [COL_W-1:0] d;
      for (int i = 0; i < COL_W/32; i++) d[i*32 +: 32] = $urandom();
      return d;
   endfunction

   function automatic int exp_windows(input int n);
      return (PAD > 0) ? n : n - K + 1;
   endfunction

   function automatic void line_reset();
      line_q.delete();
      for (int p = 0; p < PAD; p++) line_q.push_back('0);
   endfunction

   // Window over the K most recent columns of the current line.
   function automatic void push_win(input logic last);
      win_t w;
      int   base;
      base   = line_q.size() - K;
      w.data = '0;
      for (int u = 0; u < UNIT_NUM; u++)
         for (int k = 0; k < K; k++)
            w.data[(u*K + k)*TD +: TD] = line_q[base + k][u*TD +: TD];
      w.last = last;
      exp_q.push_back(w);
   endfunction

   function automatic void model_accept(input logic [COL_W-1:0] d, input logic last);
      int n;
      line_q.push_back(d);
      if (line_q.size() >= K) push_win(last && (PAD == 0));
      if (last) begin
         n = line_q.size() - PAD;
         if (n < K - 2*PAD) exp_short++;
         for (int p = 1; p <= PAD; p++) begin
            line_q.push_back('0);
            if (line_q.size() >= K) push_win(p == PAD);
         end
         line_reset();
      end
   endfunction

   task automatic tick_a();
      @(negedge clk);
      acc_seen = 0;
      if (rst) begin
         chk("ready_in_reset", column_ready, 0);
         exp_q.delete();
         line_reset();
         stall_prev = 0;
      end else begin
         if (stall_prev) begin
            n_chk++;
            if (win_valid === 1'b1 && win_data === prev_data && win_last === prev_last) n_pass++;
            else $display("FAIL stall_hold: got valid=%b last=%b data[31:0]=%h, want valid=1 last=%b data[31:0]=%h",
                          win_valid, win_last, win_data[31:0], prev_last, prev_data[31:0]);
         end
         if (win_valid && win_ready) begin
            n_win++;
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL extra_window: got data[31:0]=%h, want no window", win_data[31:0]);
            end else begin
               chk_win(win_data, win_last, exp_q.pop_front());
            end
         end
         if (short_line) n_short++;
         if (!column_ready) n_cr_low++;
         if (column_valid && column_ready) begin
            acc_seen = 1;
            model_accept(column_data_in, column_last);
         end
         stall_prev = win_valid && !win_ready;
         prev_data  = win_data;
         prev_last  = win_last;
      end
   endtask

   task automatic tick_b();
      @(posedge clk);
      #1;
      case (wr_mode)
         0:       win_ready = 1'b1;
         1:       win_ready = ~win_ready;
         default: win_ready = ($urandom_range(0, 3) != 0);
      endcase
   endtask

   task automatic tick();
      tick_a();
      tick_b();
   endtask

   task automatic send_col(input logic [COL_W-1:0] d, input logic last);
      int n = 0;
      column_valid   = 1'b1;
      column_data_in = d;
      column_last    = last;
      do begin
         tick();
         n++;
      end while (!acc_seen && n < 64);
      if (!acc_seen) begin
         n_chk++;
         $display("FAIL col_accept_timeout: got no accept in %0d cycles, want accept", n);
      end
      column_valid = 1'b0;
      column_last  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || win_valid) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) begin
         n_chk++;
         $display("FAIL drain_timeout: got %0d windows pending, want 0", exp_q.size());
      end
   endtask

   function automatic void add_row(input logic vld, input logic last, input logic wrdy,
                                   input logic [7:0] col, input logic cr, input logic wv,
                                   input logic wl, input logic [7:0] s0, input logic sh);
      vec_t r;
      r.vld = vld; r.last = last; r.wrdy = wrdy; r.col = col;
      r.cr = cr; r.wv = wv; r.wl = wl; r.s0 = s0; r.sh = sh;
      tbl.push_back(r);
   endfunction

   initial begin
      int w0;
      int c0;
      int len;
      rst            = 1'b1;
      column_valid   = 1'b0;
      column_last    = 1'b0;
      column_data_in = '0;
      win_ready      = 1'b1;
      line_reset();
      tick();
      tick();
      chk("reset_valid", win_valid, 0);
      chk("reset_last", win_last, 0);
      chk("reset_short", short_line, 0);
      chk("reset_data_zero", |win_data, 0);
      rst = 1'b0;

`ifndef COLWIN_ZERO_PAD_EN
      // 8-column line, free-running downstream
      for (int i = 0; i < 8; i++)
         add_row(1, i == 7, 1, 8'(i), 1, i >= 3, 0, (i >= 3) ? 8'(i - 3) : 8'd0, 0);
      add_row(0, 0, 1, 0, 1, 1, 1, 5, 0);
      add_row(0, 0, 1, 0, 1, 0, 0, 0, 0);
      // 2-column short line then a 4-column line
      add_row(1, 0, 1, 0, 1, 0, 0, 0, 0);
      add_row(1, 1, 1, 1, 1, 0, 0, 0, 0);
      add_row(1, 0, 1, 0, 1, 0, 0, 0, 1);
      add_row(1, 0, 1, 1, 1, 0, 0, 0, 0);
      add_row(1, 0, 1, 2, 1, 0, 0, 0, 0);
      add_row(1, 1, 1, 3, 1, 1, 0, 0, 0);
      add_row(0, 0, 1, 0, 1, 1, 1, 1, 0);
      add_row(0, 0, 1, 0, 1, 0, 0, 0, 0);
      // two 3-column lines back to back
      add_row(1, 0, 1, 0, 1, 0, 0, 0, 0);
      add_row(1, 0, 1, 1, 1, 0, 0, 0, 0);
      add_row(1, 1, 1, 2, 1, 0, 0, 0, 0);
      add_row(1, 0, 1, 0, 1, 1, 1, 0, 0);
      add_row(1, 0, 1, 1, 1, 0, 0, 0, 0);
      add_row(1, 1, 1, 2, 1, 0, 0, 0, 0);
      add_row(0, 0, 1, 0, 1, 1, 1, 0, 0);
      add_row(0, 0, 1, 0, 1, 0, 0, 0, 0);
      foreach (tbl[i]) begin
         column_valid   = tbl[i].vld;
         column_last    = tbl[i].last;
         column_data_in = col_of(tbl[i].col);
         win_ready      = tbl[i].wrdy;
         tick_a();
         chk("t_ready", column_ready, tbl[i].cr);
         chk("t_valid", win_valid, tbl[i].wv);
         chk("t_short", short_line, tbl[i].sh);
         if (tbl[i].wv) begin
            chk("t_last", win_last, tbl[i].wl);
            chk("t_slot0", win_data[7:0], tbl[i].s0);
         end
         tick_b();
      end
      column_valid = 1'b0;
      column_last  = 1'b0;
      chk("t_short_count", n_short, exp_short);
`endif

      // stalled downstream: ready toggles every cycle
      w0 = n_win;
      wr_mode = 1;
      win_ready = 1'b1;
      for (int i = 0; i < 5; i++) send_col(col_of(8'(8'h40 + i)), i == 4);
      drain();
      chk("stall_windows", n_win - w0, exp_windows(5));
      wr_mode = 0;
      win_ready = 1'b1;

      // reset in the middle of a line
      w0 = n_win;
      send_col(col_of(8'h20), 1'b0);
      send_col(col_of(8'h21), 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) send_col(col_of(8'(8'h30 + i)), i == 2);
      drain();
      chk("reset_windows", n_win - w0, exp_windows(3));

      // 4-column line, counting column_ready low cycles
      w0 = n_win;
      c0 = n_cr_low;
      for (int i = 0; i < 4; i++) send_col(col_of(8'(i)), i == 3);
      drain();
      chk("line4_windows", n_win - w0, exp_windows(4));
      chk("line4_ready_low", n_cr_low - c0, PAD);

      // random lines, random gaps and random backpressure
      wr_mode = 2;
      for (int l = 0; l < 40; l++) begin
         len = $urandom_range(1, 8);
         for (int c = 0; c < len; c++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send_col(rand_col(), c == len - 1);
         end
      end
      drain();
      wr_mode = 0;
      win_ready = 1'b1;
      tick();

      chk("short_total", n_short, exp_short);
      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by time limit, want finish");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/col_window_packer.md
COL_WINDOW_PACKER -- requirements
Module: col_window_packer

Interface
REQ-001 SHALL have parameter TILE_H, default 6, rows per column per unit.
REQ-002 SHALL have parameter UNIT_NUM, default 16, parallel units.
REQ-003 SHALL have parameter DATA_W, default 8, bits per pixel.
REQ-004 SHALL have parameter K, default 3, window width in columns; legal values are odd and 3..7.
REQ-005 SHALL have port clk, input, 1, the only clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port column_data_in, input, UNIT_NUM*TILE_H*DATA_W, one column per unit.
REQ-008 SHALL have port column_valid, input, 1, column_data_in is valid.
REQ-009 SHALL have port column_last, input, 1, marks the last column of a line; qualified by column_valid.
REQ-010 SHALL have port column_ready, output, 1; the block accepts a column on column_valid && column_ready.
REQ-011 SHALL have port win_data, output, UNIT_NUM*K*TILE_H*DATA_W, the window.
REQ-012 SHALL have port win_valid, output, 1, win_data is valid.
REQ-013 SHALL have port win_last, output, 1, marks the last window of a line.
REQ-014 SHALL have port win_ready, input, 1, downstream accepts a window on win_valid && win_ready.
REQ-015 SHALL have port short_line, output, 1, one-cycle pulse when a line ends before a window can be formed.

Function
REQ-016 SHALL keep a K-column shift register; each accepted column shifts in at slot K-1 and slot 0 is the oldest.
REQ-017 SHALL pack, per unit u, slot k of win_data at bit offset (u*K + k)*TILE_H*DATA_W.
REQ-018 SHALL keep a column counter and an FSM with states FILL, STREAM and FLUSH; FLUSH exists only when padding is compiled in.
REQ-019 SHALL stay in FILL while fewer than K columns are held, and go to STREAM on the accept that makes K columns held.
REQ-020 SHALL load the output register with a window on every accept while in STREAM, and also on the accept that causes FILL->STREAM; win_valid rises the following cycle (latency 1).
REQ-021 SHALL drive column_ready = (!win_valid || win_ready) && state != FLUSH, giving a single output register and full throughput with no bubbles.
REQ-022 SHALL hold win_data, win_valid and win_last stable while win_valid && !win_ready.
REQ-023 SHALL, on an accepted column_last, set win_last on the window that column completes, clear the counter and go to FILL (or to FLUSH when padding is enabled).
REQ-024 SHALL, when column_last is accepted with fewer than K columns held, emit no window, pulse short_line for one cycle, clear the counter and go to FILL.
REQ-025 SHALL let a line's first column be accepted in the same cycle its previous line's last window is accepted.
REQ-026 SHALL produce N-K+1 windows for a line of N >= K columns when padding is disabled.

Reset
REQ-027 SHALL, when rst is high at a clock edge, clear win_valid, win_last, short_line, win_data, the counter and the shift register, and set the state to FILL.
REQ-028 SHALL drop any partial line on reset mid-line, and SHALL drop any window held in the output register without it being transferred.
REQ-029 SHALL hold column_ready low during the reset cycle and drive it per REQ-021 from the next cycle.

Configuration
REQ-030 SHALL, when COLWIN_ZERO_PAD_EN is defined, preload P=(K-1)/2 zero columns at line start, count them as held, and after column_last enter FLUSH to shift in P zero columns, emitting one window per zero column, with win_last on the final one. This yields N windows per line; column_ready is low in FLUSH; FLUSH returns to FILL when done, and short_line is used only if N < K-2P.
REQ-031 SHALL have no zero preload, no FLUSH state and no pad logic when COLWIN_ZERO_PAD_EN is not defined.

Structure
REQ-032 SHALL place the FSM state typedef (FILL, STREAM, FLUSH), the default TILE_H/UNIT_NUM/DATA_W/K constants and the slot-offset helper in package colwin_pkg.
REQ-033 SHALL implement the K-slot shift register with preload as sub-module colwin_shift_reg; the FSM, counter and output register stay in the top level.

Verification (K=3, TILE_H=6, UNIT_NUM=16, DATA_W=8; column c carries the value c in every byte)
REQ-034 SHALL test, pad off, 8 columns with win_ready=1 -> 6 windows, the first with slots (0,1,2) one cycle after column 2 is accepted, win_last on window (5,6,7), and column_ready always 1.
REQ-035 SHALL test, pad off, 5 columns with win_ready toggling 1,0 -> 3 windows, each held stable while stalled, with no loss and no duplicates.
REQ-036 SHALL test, pad off, a 2-column line followed by a 4-column line -> short_line pulses once, then windows (0,1,2) and (1,2,3) of the second line.
REQ-037 SHALL test rst asserted after 2 columns of a line, then 3 new columns -> exactly 1 window, built only from the new columns.
REQ-038 SHALL test, pad on, 4 columns -> 4 windows (Z,0,1), (0,1,2), (1,2,3) and (2,3,Z), where Z is zero; column_ready is low for 1 cycle during FLUSH, and win_last is on (2,3,Z).
REQ-039 SHALL test back-to-back lines of 3 and 3 columns with no gap, pad off -> 2 windows, both with win_last, and no dropped column.
